// File: rtl/regfile_pkg.sv
// Shared constants and index-width helper for the scoreboarded register file.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default register width/count and index_width(), which sizes the
// index typedef each module declares from its own NREGS.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_NREGS  = 4;

    // Width of a register index for a file of n entries; a module declares
    // its index type as logic [index_width(NREGS)-1:0]. Floors at 1 bit so a
    // degenerate count still yields a legal vector.
    function automatic int index_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: one bit per register plus a registered population count.
// Latency: set/clear land at the next clk edge; pending and count are registered.
// Backpressure: none; one set and one clear are accepted every cycle.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   set_en, set_idx    mark set_idx pending (wins over a clear of the same index)
//   clr_en, clr_idx    clear pending on clr_idx
//   pending            pending vector, bit i = register i
//   count              number of set bits in pending
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = DEFAULT_NREGS,
    parameter int AW    = index_width(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  logic [AW-1:0]    set_idx,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_idx,
    output logic [NREGS-1:0] pending,
    output logic [AW:0]      count
);

    logic [NREGS-1:0] pending_nxt;
    logic [AW:0]      count_nxt;
    logic             inc;
    logic             dec;

    // Clear first, then set, so a set aimed at the same index wins.
    always_comb begin
        pending_nxt = pending;
        if (clr_en) begin
            pending_nxt[clr_idx] = 1'b0;
        end
        if (set_en) begin
            pending_nxt[set_idx] = 1'b1;
        end
    end

    // The count tracks transitions only: a set on an already-pending bit adds
    // nothing, and a clear that loses to a same-index set removes nothing.
    // At most one +1 and one -1 per cycle, so the count stays in 0..NREGS.
    always_comb begin
        inc = set_en && !pending[set_idx];
        dec = clr_en && pending[clr_idx] && !(set_en && (set_idx == clr_idx));
        unique case ({inc, dec})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            count   <= '0;
        end else begin
            pending <= pending_nxt;
            count   <= count_nxt;
        end
    end

endmodule : regfile_scoreboard

// File: rtl/scoreboard_register_file.sv
// Register file with per-register pending (busy) scoreboard and a fixed tap port.
// Latency: reads combinational; writes and pending updates visible after the clk edge.
// Backpressure: none; a write and a busy_set are accepted every cycle.
//
// Ports:
//   clk, reset                rising-edge clock, synchronous active-high reset
//   r_a, r_b                  read indices; data_a/data_b, busy_a/busy_b are their results
//   write_en/reg/value        write strobe, index and data; also clears pending[write_reg]
//   busy_set, busy_reg        mark busy_reg pending (multi-cycle producer issued)
//   data_tap                  contents of register TAP_REG, same read rules as port A
//   any_busy, busy_count      OR and population count of the pending bits
// Build option: REGFILE_BYPASS_EN forwards the in-flight write to reads of the
// same index in the same cycle; without it reads see the stored state.
module scoreboard_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int NREGS   = DEFAULT_NREGS,
    parameter int TAP_REG = 1,
    parameter int R0_ZERO = 0,
    localparam int AW     = index_width(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     r_a,
    input  logic [AW-1:0]     r_b,
    input  logic              write_en,
    input  logic [AW-1:0]     write_reg,
    input  logic [DATA_W-1:0] write_value,
    input  logic              busy_set,
    input  logic [AW-1:0]     busy_reg,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic [DATA_W-1:0] data_tap,
    output logic              any_busy,
    output logic [AW:0]       busy_count
);

    typedef logic [AW-1:0] idx_t;

    localparam idx_t TAP_IDX = idx_t'(TAP_REG);
    localparam bit   HW_ZERO = (R0_ZERO != 0);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pending;
    logic              wr_vld;
    logic              set_vld;

    // Register 0 is inert when hardwired: no storage update, never pending.
    always_comb begin
        wr_vld  = write_en && !(HW_ZERO && (write_reg == '0));
        set_vld = busy_set && !(HW_ZERO && (busy_reg == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_vld) begin
            regs[write_reg] <= write_value;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .set_en  (set_vld),
        .set_idx (busy_reg),
        .clr_en  (wr_vld),
        .clr_idx (write_reg),
        .pending (pending),
        .count   (busy_count)
    );

    // One read path shared by A, B and the tap so identical indices always
    // return identical values.
    function automatic logic [DATA_W-1:0] read_data(input idx_t idx);
        logic [DATA_W-1:0] v;
        v = regs[idx];
`ifdef REGFILE_BYPASS_EN
        if (write_en && (write_reg == idx)) begin
            v = write_value;
        end
`endif
        // Applied last so forwarding can never leak a value onto register 0.
        if (HW_ZERO && (idx == '0)) begin
            v = '0;
        end
        return v;
    endfunction

    function automatic logic read_busy(input idx_t idx);
        logic b;
        b = pending[idx];
`ifdef REGFILE_BYPASS_EN
        // The in-flight write retires the pending bit, unless a same-cycle
        // busy_set re-arms it. set_vld is already masked for register 0.
        if (write_en && (write_reg == idx)) begin
            b = set_vld && (busy_reg == idx);
        end
`endif
        return b;
    endfunction

    always_comb begin
        data_a   = read_data(r_a);
        data_b   = read_data(r_b);
        data_tap = read_data(TAP_IDX);
        busy_a   = read_busy(r_a);
        busy_b   = read_busy(r_b);
        any_busy = |pending;
    end

endmodule : scoreboard_register_file

// File: tb/tb_scoreboard_register_file.sv
module tb_scoreboard_register_file;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int D = -1;  // field not checked

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] r_a, r_b, write_reg, busy_reg;
    logic       write_en, busy_set;
    logic [7:0] write_value;

    logic [7:0] da0, db0, tap0, da1, db1, tap1;
    logic       ba0, bb0, any0, ba1, bb1, any1;
    logic [2:0] cnt0, cnt1;

    always #5 clk = ~clk;

    scoreboard_register_file #(.DATA_W(8), .NREGS(4), .TAP_REG(1), .R0_ZERO(0)) u0 (
        .clk(clk), .reset(reset), .r_a(r_a), .r_b(r_b),
        .write_en(write_en), .write_reg(write_reg), .write_value(write_value),
        .busy_set(busy_set), .busy_reg(busy_reg),
        .data_a(da0), .data_b(db0), .busy_a(ba0), .busy_b(bb0),
        .data_tap(tap0), .any_busy(any0), .busy_count(cnt0)
    );

    scoreboard_register_file #(.DATA_W(8), .NREGS(4), .TAP_REG(1), .R0_ZERO(1)) u1 (
        .clk(clk), .reset(reset), .r_a(r_a), .r_b(r_b),
        .write_en(write_en), .write_reg(write_reg), .write_value(write_value),
        .busy_set(busy_set), .busy_reg(busy_reg),
        .data_a(da1), .data_b(db1), .busy_a(ba1), .busy_b(bb1),
        .data_tap(tap1), .any_busy(any1), .busy_count(cnt1)
    );

    typedef struct {
        int    cyc;
        int    dut;
        string name;
        int    da, db, tap, ba, bb, any, cnt;
    } exp_t;

    exp_t q[$];
    int   cycle_cnt = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic chk(input string nm, input string field, input int act, input int exp);
        if (exp < 0) return;
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h (t=%0t)", nm, field, act, exp, $time);
        end
    endtask

    // Monitor: pops every expectation issued for the current cycle and
    // compares it with what the addressed DUT presents at the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cycle_cnt) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cycle_cnt) begin
                checks++;
                errors++;
                $display("FAIL %s.stale: issued cycle %0d seen cycle %0d", e.name, e.cyc, cycle_cnt);
            end else if (e.dut == 0) begin
                chk(e.name, "data_a",     int'(da0),  e.da);
                chk(e.name, "data_b",     int'(db0),  e.db);
                chk(e.name, "data_tap",   int'(tap0), e.tap);
                chk(e.name, "busy_a",     int'(ba0),  e.ba);
                chk(e.name, "busy_b",     int'(bb0),  e.bb);
                chk(e.name, "any_busy",   int'(any0), e.any);
                chk(e.name, "busy_count", int'(cnt0), e.cnt);
            end else begin
                chk(e.name, "data_a",     int'(da1),  e.da);
                chk(e.name, "data_b",     int'(db1),  e.db);
                chk(e.name, "data_tap",   int'(tap1), e.tap);
                chk(e.name, "busy_a",     int'(ba1),  e.ba);
                chk(e.name, "busy_b",     int'(bb1),  e.bb);
                chk(e.name, "any_busy",   int'(any1), e.any);
                chk(e.name, "busy_count", int'(cnt1), e.cnt);
            end
        end
    end

    task automatic drive(input bit rst, input bit we, input int wr, input int wv,
                         input bit bs, input int br, input int ra, input int rb);
        reset       = rst;
        write_en    = we;
        write_reg   = 2'(wr);
        write_value = 8'(wv);
        busy_set    = bs;
        busy_reg    = 2'(br);
        r_a         = 2'(ra);
        r_b         = 2'(rb);
    endtask

    task automatic expect_out(input string nm, input int dut, input int da, input int db,
                              input int tap, input int ba, input int bb, input int any,
                              input int cnt);
        exp_t e;
        e.cyc = cycle_cnt; e.dut = dut; e.name = nm;
        e.da = da; e.db = db; e.tap = tap; e.ba = ba; e.bb = bb; e.any = any; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick;
        tick;

        // Reset state on both builds of the file.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("reset0", 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("reset1", 1, 0, 0, 0, 0, 0, 0, 0);
        tick;

        // Write A5 to r2, then read it; tap (r1) stays 0.
        drive(0, 1, 2, 'hA5, 0, 0, 2, 3);
        expect_out("wr_r2", 0, BYP ? 'hA5 : 0, 0, 0, 0, 0, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 2, 0);
        expect_out("rd_r2", 0, 'hA5, 0, 0, 0, 0, 0, 0);
        tick;

        // Write 3C to r1 while reading it on B; tap is r1.
        drive(0, 1, 1, 'h3C, 0, 0, 2, 1);
        expect_out("wr_r1", 0, 'hA5, BYP ? 'h3C : 0, BYP ? 'h3C : 0, D, D, D, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 2, 1);
        expect_out("rd_r1", 0, 'hA5, 'h3C, 'h3C, D, D, D, 0);
        tick;

        // Pend r3 then r2; writing r3 retires it.
        drive(0, 0, 0, 0, 1, 3, 3, 0);
        expect_out("set_r3", 0, D, D, D, 0, D, 0, 0);
        tick;
        drive(0, 0, 0, 0, 1, 2, 3, 2);
        expect_out("set_r2", 0, D, D, D, 1, 0, 1, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0, 3, 2);
        expect_out("two_pend", 0, D, D, D, 1, 1, 1, 2);
        tick;
        drive(0, 1, 3, 'h77, 0, 0, 3, 2);
        expect_out("wr_r3", 0, BYP ? 'h77 : 0, D, D, BYP ? 0 : 1, 1, 1, 2);
        tick;
        drive(0, 0, 0, 0, 0, 0, 3, 2);
        expect_out("r3_done", 0, 'h77, D, D, 0, 1, 1, 1);
        tick;

        // Set and write the already-pending r2 together: stays pending, no count change.
        drive(0, 1, 2, 'h5A, 1, 2, 0, 2);
        expect_out("setwr_r2", 0, D, BYP ? 'h5A : 'hA5, D, D, 1, D, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 2);
        expect_out("setwr_r2_after", 0, D, 'h5A, D, D, 1, 1, 1);
        tick;

        // Set and write the idle r1 together: ends pending, count +1.
        drive(0, 1, 1, 'hC3, 1, 1, 2, 1);
        expect_out("setwr_r1", 0, 'h5A, BYP ? 'hC3 : 'h3C, BYP ? 'hC3 : 'h3C, 1, BYP ? 1 : 0, 1, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0, 2, 1);
        expect_out("setwr_r1_after", 0, 'h5A, 'hC3, 'hC3, 1, 1, 1, 2);
        tick;

        // Re-set an already-pending register.
        drive(0, 0, 0, 0, 1, 1, 1, 0);
        expect_out("reset_pend", 0, D, D, D, 1, D, 1, 2);
        tick;
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        expect_out("reset_pend_after", 0, D, D, D, 1, D, 1, 2);
        tick;

        // r0: write FF and set busy; hardwired copy ignores both.
        drive(0, 1, 0, 'hFF, 1, 0, 0, 0);
        expect_out("r0_u1", 1, 0, 0, 'hC3, 0, 0, 1, 2);
        expect_out("r0_u0", 0, BYP ? 'hFF : 0, D, D, BYP ? 1 : 0, D, D, 2);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("r0_u1_after", 1, 0, 0, D, 0, 0, 1, 2);
        expect_out("r0_u0_after", 0, 'hFF, 'hFF, D, 1, 1, 1, 3);
        tick;

        // Same index on A, B and tap.
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        expect_out("same_idx0", 0, 'hC3, 'hC3, 'hC3, 1, 1, D, D);
        expect_out("same_idx1", 1, 'hC3, 'hC3, 'hC3, 1, 1, D, D);
        tick;

        // Reset with pending registers and a write plus set presented.
        drive(1, 1, 3, 'h99, 1, 3, 3, 2);
        expect_out("rst_mid", 0, D, D, D, D, D, D, 3);
        tick;
        drive(0, 0, 0, 0, 0, 0, 2, 3);
        expect_out("post_rst0", 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("post_rst1", 1, 0, 0, 0, 0, 0, 0, 0);
        tick;

        // Fill every pending bit, then retire one.
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, i, 0, 0);
            expect_out("fill0", 0, D, D, D, D, D, D, i);
            expect_out("fill1", 1, D, D, D, D, D, D, (i == 0) ? 0 : i - 1);
            tick;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("full0", 0, D, D, D, 1, 1, 1, 4);
        expect_out("full1", 1, D, D, D, 0, 0, 1, 3);
        tick;
        drive(0, 1, 0, 'h11, 1, 3, 0, 0);
        expect_out("full_set0", 0, D, D, D, D, D, D, 4);
        expect_out("full_set1", 1, D, D, D, D, D, D, 3);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 3);
        expect_out("retire0", 0, 'h11, D, D, 0, 1, 1, 3);
        expect_out("retire1", 1, 0, D, D, 0, 1, 1, 3);
        tick;

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        tick;
        if (q.size() != 0) begin
            $display("FAIL leftover: %0d expectations never compared, expected 0", q.size());
            errors += q.size();
            checks += q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_scoreboard_register_file

// File: doc/scoreboard_register_file.md
SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

Interface
REQ-001 Parameter DATA_W, default 8, register width in bits (>=1).
REQ-002 Parameter NREGS, default 4, register count; power of two, >=2; AW = $clog2(NREGS).
REQ-003 Parameter TAP_REG, default 1, index of the register driven on data_tap; SHALL be < NREGS.
REQ-004 Parameter R0_ZERO, default 0; 1 = register 0 hardwired to zero.
REQ-005 One clock; reset is synchronous and active-high: clk input 1, rising-edge clock for all state.
REQ-006 reset input 1, synchronous active-high reset.
REQ-007 r_a, r_b input AW, read port A/B register index.
REQ-008 write_en input 1, write strobe.
REQ-009 write_reg input AW, write index.
REQ-010 write_value input DATA_W, write data.
REQ-011 busy_set input 1, marks busy_reg as pending (multi-cycle producer issued).
REQ-012 busy_reg input AW, index to mark pending.
REQ-013 data_a, data_b output DATA_W, read data for port A/B.
REQ-014 busy_a, busy_b output 1, pending flag of r_a/r_b.
REQ-015 data_tap output DATA_W, contents of register TAP_REG.
REQ-016 any_busy output 1, OR of all pending flags.
REQ-017 busy_count output AW+1, number of pending registers.

Function
REQ-018 Reads SHALL be combinational from r_a/r_b; write SHALL update the register at the clk edge where write_en=1.
REQ-019 Each register SHALL have a pending bit; busy_set=1 SHALL set pending[busy_reg] at the next edge.
REQ-020 write_en=1 SHALL clear pending[write_reg] at the next edge.
REQ-021 With busy_set and write_en targeting the same index in the same cycle, set SHALL win: data is written, and the register ends pending.
REQ-022 busy_set on an already-pending register SHALL leave it pending, with no count change and no error.
REQ-023 busy_count SHALL be registered state, updated by +1/-1/0 consistent with REQ-019..022; it SHALL never exceed NREGS or go below 0.
REQ-024 With R0_ZERO=1, register 0 SHALL read 0, ignore writes, and never become pending (busy_set to 0 ignored).
REQ-025 data_tap SHALL follow the same read rules as port A with index TAP_REG, including REQ-024 and the Configuration bypass.
REQ-026 Simultaneous reads of the same index on A, B and tap SHALL return identical values.

Reset
REQ-027 reset=1 at a clk edge SHALL clear all registers to 0 and all pending bits to 0, and set busy_count to 0, overriding write_en and busy_set that cycle.
REQ-028 After reset: data_a=data_b=data_tap=0, busy_a=busy_b=any_busy=0, busy_count=0.
REQ-029 Reset asserted mid-operation SHALL discard all pending state; no partial write SHALL survive.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN: when defined, a read (A, B, tap) whose index equals write_reg while write_en=1 SHALL return write_value in the same cycle, and busy_a/busy_b SHALL read 0 for that index unless busy_set also targets it. Under R0_ZERO=1, index 0 still SHALL read 0.
REQ-031 Without REGFILE_BYPASS_EN, reads SHALL return the pre-edge stored value and flags, and the new value SHALL be visible the cycle after the write.

Structure
REQ-032 Package regfile_pkg SHALL hold the default DATA_W/NREGS constants and a parametrisable index typedef helper; there SHALL be no port-specific typedefs.
REQ-033 Pending bits and busy_count SHALL live in sub-module regfile_scoreboard (inputs set/clear index+enable; outputs pending vector, count); the data array SHALL stay in the top.

Verification
REQ-034 Reset, then write 8'hA5 to r2; next cycle r_a=2 SHALL give data_a=8'hA5, and data_tap SHALL be 0.
REQ-035 Write 8'h3C to r1 with r_b=1 in the same cycle: data_b=8'h3C that cycle with REGFILE_BYPASS_EN, old value without it; data_tap=8'h3C the next cycle in both cases.
REQ-036 busy_set r3, then busy_set r2: busy_count=2 and any_busy=1; write r3 SHALL give busy_count=1 and busy_a(r_a=3)=0.
REQ-037 busy_set and write_en both targeting r2 in one cycle SHALL leave r2 written, busy_b(r_b=2)=1, and busy_count incremented by 1 only if r2 was previously idle.
REQ-038 R0_ZERO=1: write 8'hFF to r0 and busy_set r0 -> data_a(r_a=0)=0, busy_count unchanged.
REQ-039 Reset asserted while two registers are pending and a write is presented SHALL give all outputs 0 next cycle.
